// File: rtl/defs_escrita.sv
// ============================================================================
// Module      : defs_escrita (package)
// Description : Shared source-select codes, write-back FSM state encodings
//               and default widths for the unidade_escrita write-back stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package defs_escrita;

  localparam int LARGURA_DADOS_PADRAO = 32;
  localparam int LARGURA_END_PADRAO   = 6;
  localparam int TIMEOUT_PADRAO       = 255;
  localparam int LARGURA_CONTADOR     = 8;

  localparam logic [1:0] FONTE_ULA      = 2'b00;
  localparam logic [1:0] FONTE_MEM      = 2'b01;
  localparam logic [1:0] FONTE_PC1      = 2'b10;
  localparam logic [1:0] FONTE_IMEDIATO = 2'b11;

  localparam logic [1:0] OCIOSO     = 2'd0;
  localparam logic [1:0] ESPERA_MEM = 2'd1;
  localparam logic [1:0] ESCREVE    = 2'd2;

endpackage

`default_nettype wire

// File: rtl/temporizador_espera.sv
// ============================================================================
// Module      : temporizador_espera
// Description : 8-bit load-wait counter with clear/enable; limite flags the
//               last permitted waiting cycle (count == LIMITE-1).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module temporizador_espera
  import defs_escrita::*;
#(
  parameter int LIMITE = TIMEOUT_PADRAO
) (
  input  logic clock,
  input  logic reset_n,
  input  logic limpa,
  input  logic habilita,
  output logic limite
);

  // Cycle k of the wait sees count k-1, so the LIMITE-th cycle sees LIMITE-1.
  localparam logic [LARGURA_CONTADOR-1:0] c_ULTIMO = LARGURA_CONTADOR'(LIMITE - 1);

  logic [LARGURA_CONTADOR-1:0] r_contagem;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_contagem <= '0;
    end else if (limpa) begin
      r_contagem <= '0;
    end else if (habilita) begin
      r_contagem <= r_contagem + LARGURA_CONTADOR'(1);
    end
  end

  assign limite = (r_contagem == c_ULTIMO);

endmodule

`default_nettype wire

// File: rtl/unidade_escrita.sv
// ============================================================================
// Module      : unidade_escrita
// Description : Write-back stage driving the register-file write port; ALU,
//               load, PC+1 or immediate source, load timeout, no r0 writes.
//               Optional forwarding outputs: define UNIDADE_ESCRITA_FWD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module unidade_escrita
  import defs_escrita::*;
#(
  parameter int LARGURA_DADOS  = LARGURA_DADOS_PADRAO,
  parameter int LARGURA_END    = LARGURA_END_PADRAO,
  parameter int TIMEOUT_CICLOS = TIMEOUT_PADRAO
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               in_fonte,
  input  logic                     in_escreve,
  input  logic [LARGURA_END-1:0]   in_end,
  input  logic [LARGURA_DADOS-1:0] in_ula,
  input  logic [LARGURA_DADOS-1:0] in_pc,
  input  logic [LARGURA_DADOS-1:0] in_imediato,
  output logic                     mem_req,
  output logic [LARGURA_DADOS-1:0] mem_endereco,
  input  logic                     mem_valid,
  input  logic [LARGURA_DADOS-1:0] mem_dados,
  output logic [LARGURA_END-1:0]   end_escrita,
  output logic [LARGURA_DADOS-1:0] dados_escrita,
  output logic                     EscreveReg,
  output logic                     erro_mem,
  output logic                     fwd_valid,
  output logic                     fwd_pendente,
  output logic [LARGURA_END-1:0]   fwd_end,
  output logic [LARGURA_DADOS-1:0] fwd_dados
);

  logic [1:0]               r_estado;
  logic [1:0]               w_prox_estado;
  logic                     w_in_ready;
  logic                     w_escreve_reg;
  logic                     w_em_espera;
  logic                     w_conta;
  logic                     w_estouro;
  logic                     w_limite;
  logic                     w_aceita;
  logic                     w_aceita_mem;
  logic [LARGURA_DADOS-1:0] w_resultado;

  logic [LARGURA_END-1:0]   r_end;
  logic [LARGURA_DADOS-1:0] r_dados;
  logic                     r_escreve;
  logic                     r_mem_req;
  logic [LARGURA_DADOS-1:0] r_mem_endereco;
  logic                     r_erro_mem;

  assign w_aceita     = in_valid && w_in_ready;
  assign w_aceita_mem = w_aceita && (in_fonte == FONTE_MEM);

  temporizador_espera #(
    .LIMITE (TIMEOUT_CICLOS)
  ) u_temporizador (
    .clock    (clock),
    .reset_n  (reset_n),
    .limpa    (w_aceita_mem),
    .habilita (w_conta),
    .limite   (w_limite)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_estado <= OCIOSO;
    end else begin
      r_estado <= w_prox_estado;
    end
  end

  always_comb begin
    w_prox_estado = r_estado;
    case (r_estado)
      OCIOSO, ESCREVE: begin
        if (w_aceita) begin
          w_prox_estado = (in_fonte == FONTE_MEM) ? ESPERA_MEM : ESCREVE;
        end else begin
          w_prox_estado = OCIOSO;
        end
      end
      ESPERA_MEM: begin
        // Data arriving on the limit cycle takes priority over the timeout.
        if (mem_valid) begin
          w_prox_estado = ESCREVE;
        end else if (w_limite) begin
          w_prox_estado = OCIOSO;
        end
      end
      default: w_prox_estado = OCIOSO;
    endcase
  end

  always_comb begin
    w_em_espera   = (r_estado == ESPERA_MEM);
    w_in_ready    = !w_em_espera;
    w_escreve_reg = (r_estado == ESCREVE) && r_escreve && (r_end != '0);
    w_conta       = w_em_espera && !mem_valid;
    w_estouro     = w_conta && w_limite;
  end

  always_comb begin
    w_resultado = in_ula;
    case (in_fonte)
      FONTE_ULA, FONTE_MEM: w_resultado = in_ula;
      FONTE_PC1:            w_resultado = in_pc + LARGURA_DADOS'(1);
      FONTE_IMEDIATO:       w_resultado = in_imediato;
      default:              w_resultado = in_ula;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_end          <= '0;
      r_dados        <= '0;
      r_escreve      <= 1'b0;
      r_mem_req      <= 1'b0;
      r_mem_endereco <= '0;
      r_erro_mem     <= 1'b0;
    end else begin
      r_mem_req <= w_aceita_mem;
      if (w_aceita_mem) begin
        r_mem_endereco <= in_ula;
        r_end          <= in_end;
        r_escreve      <= in_escreve;
      end else if (w_aceita) begin
        r_dados   <= w_resultado;
        r_end     <= in_end;
        r_escreve <= in_escreve;
      end else if (w_em_espera && mem_valid) begin
        r_dados <= mem_dados;
      end
      if (w_estouro) begin
        r_erro_mem <= 1'b1;
      end
    end
  end

  assign in_ready      = w_in_ready;
  assign mem_req       = r_mem_req;
  assign mem_endereco  = r_mem_endereco;
  assign end_escrita   = r_end;
  assign dados_escrita = r_dados;
  assign EscreveReg    = w_escreve_reg;
  assign erro_mem      = r_erro_mem;

`ifdef UNIDADE_ESCRITA_FWD_EN
  // r_end holds the pending destination while a load is outstanding.
  assign fwd_valid    = w_escreve_reg;
  assign fwd_pendente = w_em_espera && r_escreve && (r_end != '0);
  assign fwd_end      = r_end;
  assign fwd_dados    = r_dados;
`else
  assign fwd_valid    = 1'b0;
  assign fwd_pendente = 1'b0;
  assign fwd_end      = '0;
  assign fwd_dados    = '0;
`endif

endmodule

`default_nettype wire

// File: doc/unidade_escrita.md
# unidade_escrita

Write-back stage that sits directly upstream of the 64×32 register file and drives its single write port (`end_escrita`, `dados_escrita`, `EscreveReg`).
- Accepts one retiring instruction per handshake from the execute stage and selects the result source: ALU, memory load, PC+1 or immediate.
- Handles multi-cycle memory loads with a timeout, and never issues a write to register 0.

## Interface
Parameters:
- `LARGURA_DADOS`, 32, data width.
- `LARGURA_END`, 6, register address width (64 registers).
- `TIMEOUT_CICLOS`, 255, maximum wait cycles for a load response (1..255; counter is 8 bits).

Ports:
- `clock` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: execute stage presents an instruction.
- `in_ready` out 1: stage can accept an instruction.
- `in_fonte` in 2: source select. 00 ULA, 01 MEM, 10 PC+1, 11 IMEDIATO.
- `in_escreve` in 1: instruction writes a register.
- `in_end` in 6: destination register.
- `in_ula` in 32: ALU result; also the load address.
- `in_pc` in 32: instruction PC.
- `in_imediato` in 32: immediate value.
- `mem_req` out 1: one-cycle load request.
- `mem_endereco` out 32: load address.
- `mem_valid` in 1: load data valid.
- `mem_dados` in 32: load data.
- `end_escrita` out 6: to register file.
- `dados_escrita` out 32: to register file.
- `EscreveReg` out 1: to register file.
- `erro_mem` out 1: sticky load-timeout flag.
- `fwd_valid` out 1: forwarding, see Configuration.
- `fwd_pendente` out 1: forwarding, see Configuration.
- `fwd_end` out 6: forwarding, see Configuration.
- `fwd_dados` out 32: forwarding, see Configuration.

## Operation
States:
- OCIOSO: no instruction in flight.
- ESPERA_MEM: waiting for a load response.
- ESCREVE: result being written this cycle.

Handshake:
- `in_ready` = 1 in OCIOSO and ESCREVE; 0 in ESPERA_MEM.
- Acceptance occurs when `in_valid && in_ready` at a rising edge.

Accept with fonte ≠ MEM:
- Compute the result:
  - ULA: `in_ula`.
  - PC+1: `in_pc + 1` modulo 2^32.
  - IMEDIATO: `in_imediato`.
- Register the result into `dados_escrita` and `in_end` into `end_escrita`.
- Next state: ESCREVE.

Accept with fonte = MEM:
- Register `mem_endereco` ← `in_ula` and latch `in_end` / `in_escreve`.
- Pulse `mem_req` for the following cycle.
- Clear the wait counter; next state: ESPERA_MEM.

ESPERA_MEM:
- `mem_valid` = 1: latch `mem_dados`; next state ESCREVE.
- Otherwise: increment the counter.
- When the counter reaches `TIMEOUT_CICLOS`: set `erro_mem`, discard the load (no write), return to OCIOSO.
- `mem_valid` in the same cycle the limit is reached: the data wins and no error is raised.

ESCREVE:
- `EscreveReg` = `escreve_latched && end_escrita != 0`.
- Next state: ESCREVE if a new non-MEM instruction is accepted, ESPERA_MEM if a MEM instruction is accepted, else OCIOSO.
- Back-to-back non-MEM instructions therefore write every cycle.

Other rules:
- `mem_valid` outside ESPERA_MEM is ignored.
- Destination 0 never produces `EscreveReg` = 1, regardless of source.
- `erro_mem` clears only on reset.

## Timing
- Non-MEM instruction accepted at edge N → `EscreveReg`/`end_escrita`/`dados_escrita` valid during cycle N+1 → register file captures at edge N+1.
- MEM instruction accepted at edge N → `mem_req` = 1 during cycle N+1 only.
- `mem_valid` sampled at edge M → write during cycle M+1. `mem_valid` may arrive as early as cycle N+1.
- Timeout: `erro_mem` rises one cycle after the `TIMEOUT_CICLOS`-th waiting cycle; `in_ready` returns to 1 at the same time.
- Reset values: state OCIOSO; all outputs 0 except `in_ready` = 1.
- Reset during ESPERA_MEM abandons the load; any later `mem_valid` is ignored.

## Configuration
Macro: `UNIDADE_ESCRITA_FWD_EN`.

Defined:
- `fwd_valid`/`fwd_end`/`fwd_dados` mirror `EscreveReg`/`end_escrita`/`dados_escrita` each cycle.
- `fwd_pendente` = 1 while in ESPERA_MEM with a nonzero destination and escreve set; `fwd_end` then shows the pending destination so upstream can stall.

Undefined:
- All `fwd_*` outputs tied to 0; no forwarding logic synthesized.

## Structure
- Shared include/package `defs_escrita`: source codes (FONTE_ULA, FONTE_MEM, FONTE_PC1, FONTE_IMEDIATO), state encodings, default widths.
- One sub-module `temporizador_espera`: 8-bit wait counter with clear, enable and `limite` compare output.

## Test plan
- ULA, `in_ula` = 0x000000AB, dest 5, escreve = 1 → next cycle `EscreveReg` = 1, `end_escrita` = 5, `dados_escrita` = 0x000000AB.
- IMEDIATO 0x12345678, dest 0, escreve = 1 → `EscreveReg` stays 0 throughout.
- MEM, `in_ula` = 0x10, dest 7; `mem_valid` 3 cycles after `mem_req` with 0xDEADBEEF → `mem_endereco` = 0x10, `in_ready` = 0 while waiting, write 0xDEADBEEF to r7 one cycle after `mem_valid`.
- `TIMEOUT_CICLOS` = 4, MEM with no response → `erro_mem` = 1, no write, `in_ready` = 1; a later `mem_valid` is ignored.
- PC+1 with `in_pc` = 0xFFFFFFFF, dest 31 → `dados_escrita` = 0x00000000; then three back-to-back ULA instructions produce three consecutive write cycles.
- Reset asserted mid-ESPERA_MEM, then `mem_valid` after release → no write; all outputs at reset values.
